// File: rtl/rc5_pkg.sv
// Shared RC5-16 definitions: word size, magic constants, key-schedule FSM states
// and the subkey table type used by both the key expander and the round engine.
package rc5_pkg;

  localparam int W           = 16;
  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;
  localparam int MAX_ROUNDS  = 16;
  localparam int MAX_SUBKEYS = 2 * MAX_ROUNDS + 2;
  localparam int KEY_WORDS   = 4;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    MIX,
    DONE
  } state_t;

  typedef logic [W-1:0] subkey_array_t [0:MAX_SUBKEYS-1];

  // Round counts above the supported maximum behave as the maximum.
  function automatic logic [4:0] clamp_rounds(input logic [4:0] r);
    return (r > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : r;
  endfunction

endpackage

// File: rtl/rotl.sv
// Left rotator of a W-bit word by a variable amount (0..W-1).
module rotl #(
  parameter int W = 16
) (
  input  logic [W-1:0]         din,
  input  logic [$clog2(W)-1:0] amt,
  output logic [W-1:0]         dout
);

  logic [2*W-1:0] dbl;

  // Shifting the word concatenated with itself leaves the rotation in the top half.
  assign dbl  = {din, din} << amt;
  assign dout = dbl[2*W-1:W];

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16/r/8 key schedule: fills S[0..t-1] with the P/Q progression, then mixes
// the secret key into it one word per cycle and holds the table until restarted.
module rc5_key_expand #(
  parameter int KEY_WORDS  = 4,
  parameter int MAX_ROUNDS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [16*KEY_WORDS-1:0] key,
  input  logic [4:0]              num_rounds,
  output logic [rc5_pkg::W-1:0]   subkeys [0:2*MAX_ROUNDS+1],
  output logic                    busy,
  output logic                    ready,
  output rc5_pkg::state_t         state
);

  import rc5_pkg::*;

  localparam int NSUB = 2 * MAX_ROUNDS + 2;

  // Handshake: start is sampled only in IDLE/DONE; ready=1 means the table is
  // complete and frozen until the next accepted start; busy covers INIT and MIX.
  state_t       next_state;
  logic [W-1:0] s [0:NSUB-1];
  logic [W-1:0] l [0:KEY_WORDS-1];
  logic [W-1:0] a, b;
  logic [5:0]   i, t_reg, last_i, t_new;
  logic [1:0]   j;
  logic [6:0]   step, last_step;
  logic [4:0]   r_cl;
  logic         accept;
  logic [W-1:0] init_val, sum_a, a_new, ab, sum_b, b_new;

  assign subkeys = s;

  assign r_cl   = clamp_rounds(num_rounds);
  assign t_new  = {r_cl, 1'b0} + 6'd2;
  assign last_i = t_reg - 6'd1;
  // Mixing runs 3*max(t, c) steps; for r = 0 the key length dominates.
  assign last_step = (t_reg < 6'd4) ? 7'd11 : ({1'b0, t_reg} * 7'd3 - 7'd1);
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    init_val = P16;
    if (i != 6'd0) init_val = s[i - 6'd1] + Q16;
  end

  assign sum_a = s[i] + a + b;
  assign ab    = a_new + b;
  assign sum_b = l[j] + ab;

  rotl #(.W(W)) rot_a (.din(sum_a), .amt(4'd3),   .dout(a_new));
  rotl #(.W(W)) rot_b (.din(sum_b), .amt(ab[3:0]), .dout(b_new));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = INIT;
      INIT:    if (i == last_i) next_state = MIX;
      MIX:     if (step == last_step) next_state = DONE;
      DONE:    if (start) next_state = INIT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == INIT) || (state == MIX);
    ready = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      for (int k = 0; k < NSUB; k++) s[k] <= '0;
      for (int m = 0; m < KEY_WORDS; m++) l[m] <= rst ? '0 : key[16*m +: 16];
      a     <= '0;
      b     <= '0;
      i     <= '0;
      j     <= '0;
      step  <= '0;
      t_reg <= rst ? 6'd0 : t_new;
    end else if (state == INIT) begin
      s[i] <= init_val;
      i    <= (i == last_i) ? 6'd0 : i + 6'd1;
    end else if (state == MIX) begin
      s[i] <= a_new;
      l[j] <= b_new;
      a    <= a_new;
      b    <= b_new;
      i    <= (i == last_i) ? 6'd0 : i + 6'd1;
      j    <= j + 2'd1;
      step <= step + 7'd1;
    end
  end

endmodule
